// File: rtl/serial_paralelo_sync_ctrl.sv
// Receive-path sync controller: hunts for comma alignment by requesting bit slips,
// declares the lane active after a run of commas, and forwards non-comma payload bytes.
module serial_paralelo_sync_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4,
  parameter int         SLIP_WAIT  = 2,
  parameter int         MAX_GAP    = 16
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic       bit_slip,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [3:0] BC_counter
);

  localparam int HW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam logic [HW:0]   SLIP_LIM = SLIP_WAIT[HW:0];
  localparam logic [GW-1:0] GAP_LIM  = MAX_GAP[GW-1:0];
  localparam logic [3:0]    SYNC_LIM = SYNC_COUNT[3:0];

  typedef enum logic [1:0] {HUNT, COUNT, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hunt_cnt, hunt_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt, gap_inc;
  logic [HW:0]   hunt_inc;
  logic [3:0]    bc_nxt;
  logic [7:0]    data_nxt;
  logic          slip_nxt, valid_nxt, is_comma;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      hunt_cnt   <= '0;
      gap_cnt    <= '0;
      BC_counter <= 4'd0;
      data_out   <= 8'h00;
      bit_slip   <= 1'b0;
      valid_out  <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_nxt;
      hunt_cnt   <= hunt_nxt;
      gap_cnt    <= gap_nxt;
      BC_counter <= bc_nxt;
      data_out   <= data_nxt;
      bit_slip   <= slip_nxt;
      valid_out  <= valid_nxt;
      active     <= (state_nxt == ACTIVE);
    end
  end

  // All outputs are registered; this block only decides what they become next edge.
  always_comb begin
    state_nxt = state;
    hunt_nxt  = hunt_cnt;
    gap_nxt   = gap_cnt;
    bc_nxt    = BC_counter;
    data_nxt  = data_out;
    slip_nxt  = 1'b0;
    valid_nxt = 1'b0;
    is_comma  = (byte_in == COMMA);
    hunt_inc  = {1'b0, hunt_cnt} + 1'b1;
    gap_inc   = gap_cnt + 1'b1;

    if (!enable) begin
      state_nxt = HUNT;
      hunt_nxt  = '0;
      gap_nxt   = '0;
      bc_nxt    = 4'd0;
    end else if (byte_vld) begin
      case (state)
        HUNT: begin
          if (is_comma) begin
            bc_nxt    = 4'd1;
            hunt_nxt  = '0;
            gap_nxt   = '0;
            state_nxt = (SYNC_COUNT == 1) ? ACTIVE : COUNT;
          end else if (hunt_inc >= SLIP_LIM && !bit_slip) begin
            slip_nxt = 1'b1;
            hunt_nxt = '0;
          end else if (hunt_inc >= SLIP_LIM) begin
            // a slip just fired; saturate so the next byte fires the following one
            hunt_nxt = SLIP_LIM[HW-1:0];
          end else begin
            hunt_nxt = hunt_inc[HW-1:0];
          end
        end
        COUNT: begin
          if (is_comma) begin
            bc_nxt = BC_counter + 4'd1;
            if (bc_nxt == SYNC_LIM) begin
              state_nxt = ACTIVE;
              gap_nxt   = '0;
            end
          end else begin
            bc_nxt    = 4'd0;
            hunt_nxt  = '0;
            state_nxt = HUNT;
          end
        end
        ACTIVE: begin
          bc_nxt = SYNC_LIM;
          if (is_comma) begin
            gap_nxt = '0;
          end else if (gap_inc > GAP_LIM) begin
            state_nxt = HUNT;
            bc_nxt    = 4'd0;
            gap_nxt   = '0;
            hunt_nxt  = '0;
          end else begin
            gap_nxt   = gap_inc;
            data_nxt  = byte_in;
            valid_nxt = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_sync_ctrl.sv
// Self-checking bench for serial_paralelo_sync_ctrl: directed scenarios plus random
// traffic, all compared against a byte-level behavioural model of the sync rules.
module tb_serial_paralelo_sync_ctrl;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int SYNC_COUNT = 4;
  localparam int SLIP_WAIT  = 2;
  localparam int MAX_GAP    = 16;

  logic       clk_4f, reset, enable, byte_vld;
  logic [7:0] byte_in;
  logic       bit_slip, valid_out, active;
  logic [7:0] data_out;
  logic [3:0] BC_counter;

  serial_paralelo_sync_ctrl #(
    .COMMA(COMMA), .SYNC_COUNT(SYNC_COUNT), .SLIP_WAIT(SLIP_WAIT), .MAX_GAP(MAX_GAP)
  ) dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable), .byte_in(byte_in), .byte_vld(byte_vld),
    .bit_slip(bit_slip), .data_out(data_out), .valid_out(valid_out), .active(active),
    .BC_counter(BC_counter)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int errors = 0;

  // Model state: 0 = hunting, 1 = counting commas, 2 = synchronized.
  int         m_mode, m_commas, m_misses, m_gap;
  logic       e_slip, e_valid, e_active;
  logic [7:0] e_data;
  logic [3:0] e_bc;
  logic [14:0] obs, exp_vec;

  assign obs     = {bit_slip, valid_out, active, BC_counter, data_out};
  assign exp_vec = {e_slip, e_valid, e_active, e_bc, e_data};

  task automatic model_reset();
    m_mode = 0; m_commas = 0; m_misses = 0; m_gap = 0;
    e_slip = 0; e_valid = 0; e_active = 0; e_data = 8'h00; e_bc = 4'd0;
  endtask

  task automatic model_step(input logic en, input logic vld, input logic [7:0] b);
    logic prev_slip;
    prev_slip = e_slip;
    e_slip  = 0;
    e_valid = 0;
    if (!en) begin
      m_mode = 0; m_commas = 0; m_misses = 0; m_gap = 0;
    end else if (vld) begin
      if (m_mode == 0) begin
        if (b == COMMA) begin
          m_commas = 1; m_misses = 0; m_gap = 0;
          m_mode = (SYNC_COUNT == 1) ? 2 : 1;
        end else begin
          m_misses++;
          if (m_misses >= SLIP_WAIT && !prev_slip) begin
            e_slip = 1; m_misses = 0;
          end else if (m_misses > SLIP_WAIT) m_misses = SLIP_WAIT;
        end
      end else if (m_mode == 1) begin
        if (b == COMMA) begin
          m_commas++;
          if (m_commas == SYNC_COUNT) begin m_mode = 2; m_gap = 0; end
        end else begin
          m_commas = 0; m_mode = 0; m_misses = 0;
        end
      end else begin
        if (b == COMMA) m_gap = 0;
        else begin
          m_gap++;
          if (m_gap > MAX_GAP) begin
            m_mode = 0; m_commas = 0; m_gap = 0; m_misses = 0;
          end else begin
            e_data = b; e_valid = 1;
          end
        end
      end
    end
    e_active = (m_mode == 2);
    e_bc = m_commas[3:0];
  endtask

  task automatic apply_byte(input logic en, input logic vld, input logic [7:0] b);
    @(negedge clk_4f);
    enable = en; byte_vld = vld; byte_in = b;
    @(posedge clk_4f);
    model_step(en, vld, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_4f);
    reset = 1'b1; enable = 1'b1; byte_vld = 1'b0; byte_in = 8'h00;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic sync_up();
    do_reset();
    for (int i = 0; i < SYNC_COUNT; i++) apply_byte(1'b1, 1'b1, COMMA);
  endtask

  function automatic logic [7:0] rand_noncomma();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == COMMA) v = 8'h3C;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; byte_vld = 1'b0; byte_in = 8'h00;
    model_reset();
    #3;
    checks++;
    if (obs !== 15'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: observed {slip,vld,act,bc,data}=%h expected %h", obs, 15'h0);
    end
    @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic test_sync_acquire();
    do_reset();
    for (int i = 0; i < SYNC_COUNT + 1; i++) begin
      apply_byte(1'b1, (i < SYNC_COUNT), COMMA);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL sync_acquire[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_payload();
    logic [7:0] seq [4];
    seq = '{8'h11, COMMA, 8'h22, 8'h00};
    sync_up();
    for (int i = 0; i < 4; i++) begin
      apply_byte(1'b1, (i < 3), seq[i]);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL payload[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_hunt_slip();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_byte(1'b1, 1'b1, 8'h00);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL hunt_slip[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_count_abort();
    logic [7:0] seq [8];
    seq = '{COMMA, COMMA, COMMA, 8'h55, COMMA, COMMA, COMMA, COMMA};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_byte(1'b1, 1'b1, seq[i]);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL count_abort[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_gap_loss();
    sync_up();
    for (int i = 0; i < MAX_GAP + 2; i++) begin
      apply_byte(1'b1, 1'b1, rand_noncomma());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL gap_loss[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_vld_toggle();
    sync_up();
    for (int i = 0; i < 40; i++) begin
      apply_byte(1'b1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? COMMA : rand_noncomma());
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL vld_toggle[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midstream();
    sync_up();
    apply_byte(1'b1, 1'b1, 8'h33);
    checks++;
    if (obs !== exp_vec) begin
      errors++;
      $display("[TB] FAIL pre_reset: observed {slip,vld,act,bc,data}=%h expected %h", obs, exp_vec);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 15'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: observed {slip,vld,act,bc,data}=%h expected %h", obs, 15'h0);
    end
    @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic test_enable_drop();
    sync_up();
    apply_byte(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      apply_byte(1'b0, 1'b1, (i == 1) ? COMMA : 8'h44);
      checks++;
      if (obs !== exp_vec || active !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enable_drop[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      apply_byte(($urandom_range(0, 60) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0) ? COMMA : 8'($urandom_range(0, 255)));
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random[%0d]: observed {slip,vld,act,bc,data}=%h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_acquire();
    test_payload();
    test_hunt_slip();
    test_count_abort();
    test_gap_loss();
    test_vld_toggle();
    test_reset_midstream();
    test_enable_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
